// File: rtl/cpu_req_pkg.sv
// Shared types and constants for the CPU request queue: FSM states, entry width
// helper and sticky error bit positions.
package cpu_req_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait
  } state_e;

  localparam int unsigned ErrOvf  = 0;
  localparam int unsigned ErrColl = 1;
  localparam int unsigned NumErr  = 2;

  // Entry layout, MSB first: {is_wr, byte, addr, wdata}
  function automatic int unsigned entry_width(input int unsigned aw, input int unsigned bw,
                                              input int unsigned dw);
    return 1 + bw + aw + dw;
  endfunction

endpackage

// File: rtl/cpu_req_fifo.sv
// Single-clock synchronous FIFO. Pop on empty is ignored; push on full is accepted
// only when a pop happens in the same cycle.
module cpu_req_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [PtrW:0] LevelMax = DEPTH[PtrW:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]    level_q;
  logic             do_push, do_pop;

  assign full    = (level_q == LevelMax);
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      unique case ({do_push, do_pop})
        2'b10:   level_q <= level_q + (PtrW + 1)'(1);
        2'b01:   level_q <= level_q - (PtrW + 1)'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // Storage needs no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/cpu_req_queue.sv
// Host request front-end: edge-detects wr/rd strobes, queues requests and issues
// them to the bus one at a time as single-cycle pulses paced by trans_over.
module cpu_req_queue
  import cpu_req_pkg::*;
#(
  parameter int unsigned AW    = 4,
  parameter int unsigned DW    = 32,
  parameter int unsigned BW    = DW / 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr,
  input  logic                   rd,
  input  logic [BW-1:0]          byte_en,
  input  logic [AW-1:0]          addr,
  input  logic [DW-1:0]          wdata,
  input  logic                   clr_err,
  output logic                   rdata_v,
  output logic [DW-1:0]          rdata,
  output logic                   cpu_wr,
  output logic                   cpu_rd,
  output logic [BW-1:0]          cpu_byte,
  output logic [AW-1:0]          cpu_addr,
  output logic [DW-1:0]          cpu_wdata,
  input  logic                   cpu_rdata_v,
  input  logic [DW-1:0]          cpu_rdata,
  input  logic                   trans_over,
  output logic [$clog2(DEPTH):0] req_level,
  output logic                   req_full,
  output logic                   err_ovf,
  output logic                   err_coll
);

  localparam int unsigned EW = entry_width(AW, BW, DW);

  state_e            state_q, state_d;
  logic              wait_first_q, wait_first_d;
  logic              wr_ff_q, rd_ff_q;
  logic              is_wr_q;
  logic [NumErr-1:0] err_q, err_d;

  logic          we, re, req_edge, push, pop, ovf_set, coll_set;
  logic          fifo_full, fifo_empty;
  logic [EW-1:0] push_data, fifo_rdata;

  assign we       = wr & ~wr_ff_q;
  assign re       = rd & ~rd_ff_q;
  assign req_edge = we | re;
  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign push      = req_edge & (~fifo_full | pop);
  assign ovf_set   = req_edge & fifo_full & ~pop;
  assign coll_set  = we & re;
  assign push_data = {we, byte_en, addr, wdata};

  assign rdata_v  = cpu_rdata_v;
  assign rdata    = cpu_rdata;
  assign req_full = fifo_full;
  assign err_ovf  = err_q[ErrOvf];
  assign err_coll = err_q[ErrColl];

  cpu_req_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (push_data),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (req_level)
  );

  always_comb begin
    state_d      = state_q;
    wait_first_d = wait_first_q;
    pop          = 1'b0;
    cpu_wr       = 1'b0;
    cpu_rd       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty && trans_over) begin
          pop     = 1'b1;
          state_d = StIssue;
        end
      end
      StIssue: begin
        cpu_wr       = is_wr_q;
        cpu_rd       = ~is_wr_q;
        wait_first_d = 1'b1;
        state_d      = StWait;
      end
      StWait: begin
        // trans_over may still show idle the cycle right after the pulse.
        if (wait_first_q) begin
          wait_first_d = 1'b0;
        end else if (trans_over) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    err_d          = err_q & ~{NumErr{clr_err}};
    err_d[ErrOvf]  = err_d[ErrOvf] | ovf_set;
    err_d[ErrColl] = err_d[ErrColl] | coll_set;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      wait_first_q <= 1'b0;
      wr_ff_q      <= 1'b0;
      rd_ff_q      <= 1'b0;
      err_q        <= '0;
      is_wr_q      <= 1'b0;
      cpu_byte     <= '0;
      cpu_addr     <= '0;
      cpu_wdata    <= '0;
    end else begin
      state_q      <= state_d;
      wait_first_q <= wait_first_d;
      wr_ff_q      <= wr;
      rd_ff_q      <= rd;
      err_q        <= err_d;
      if (pop) {is_wr_q, cpu_byte, cpu_addr, cpu_wdata} <= fifo_rdata;
    end
  end

endmodule

// File: tb/tb_cpu_req_queue.sv
// Scoreboard bench for cpu_req_queue: accepted host requests are queued as
// expected bus commands and matched against every cpu_wr/cpu_rd pulse.
module tb_cpu_req_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr, rd, clr_err;
  logic [3:0]  byte_en, addr;
  logic [31:0] wdata;
  logic        rdata_v;
  logic [31:0] rdata;
  logic        cpu_wr, cpu_rd;
  logic [3:0]  cpu_byte, cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_rdata_v;
  logic [31:0] cpu_rdata;
  logic        trans_over;
  logic [2:0]  req_level;
  logic        req_full, err_ovf, err_coll;

  int          n_checks = 0;
  int          n_fails  = 0;
  int          cyc      = 0;
  int          drive_cyc;
  int          pulse_cnt = 0;
  logic        prev_pulse = 1'b0;
  logic [40:0] sb[$];

  cpu_req_queue #(
    .AW    (4),
    .DW    (32),
    .BW    (4),
    .DEPTH (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr          (wr),
    .rd          (rd),
    .byte_en     (byte_en),
    .addr        (addr),
    .wdata       (wdata),
    .clr_err     (clr_err),
    .rdata_v     (rdata_v),
    .rdata       (rdata),
    .cpu_wr      (cpu_wr),
    .cpu_rd      (cpu_rd),
    .cpu_byte    (cpu_byte),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_rdata_v (cpu_rdata_v),
    .cpu_rdata   (cpu_rdata),
    .trans_over  (trans_over),
    .req_level   (req_level),
    .req_full    (req_full),
    .err_ovf     (err_ovf),
    .err_coll    (err_coll)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Every bus pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && (cpu_wr || cpu_rd)) begin
      check("pulse_excl", 64'(cpu_wr & cpu_rd), 64'd0);
      check("pulse_width", 64'(prev_pulse), 64'd0);
      check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        check("pulse_fields", 64'({cpu_wr, cpu_byte, cpu_addr, cpu_wdata}),
              64'(sb.pop_front()));
      end
      pulse_cnt <= pulse_cnt + 1;
    end
    prev_pulse <= rst_n & (cpu_wr | cpu_rd);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic host_req(input logic is_wr, input logic [3:0] be, input logic [3:0] a,
                          input logic [31:0] d, input bit expect_acc);
    byte_en = be;
    addr    = a;
    wdata   = d;
    if (is_wr) wr = 1'b1;
    else rd = 1'b1;
    if (expect_acc) sb.push_back({is_wr, be, a, d});
    drive_cyc = cyc;
    tick(1);
    wr = 1'b0;
    rd = 1'b0;
    tick(1);
  endtask

  task automatic wait_pulse(input int max, output int at);
    at = -1;
    for (int i = 0; i < max; i++) begin
      if (cpu_wr || cpu_rd) begin
        at = cyc;
        break;
      end
      tick(1);
    end
    check("pulse_seen", 64'(at >= 0), 64'd1);
  endtask

  task automatic wait_count(input string tag, input int target, input int max);
    for (int i = 0; i < max; i++) begin
      if (pulse_cnt >= target) break;
      tick(1);
    end
    check(tag, 64'(pulse_cnt), 64'(target));
  endtask

  initial begin
    int at;
    int base;

    rst_n       = 1'b0;
    wr          = 1'b0;
    rd          = 1'b0;
    clr_err     = 1'b0;
    byte_en     = '0;
    addr        = '0;
    wdata       = '0;
    trans_over  = 1'b1;
    cpu_rdata_v = 1'b1;
    cpu_rdata   = 32'hCAFEF00D;
    #3;
    check("rst_cpu_wr", 64'(cpu_wr), 64'd0);
    check("rst_cpu_rd", 64'(cpu_rd), 64'd0);
    check("rst_cpu_fields", 64'({cpu_byte, cpu_addr, cpu_wdata}), 64'd0);
    check("rst_level", 64'(req_level), 64'd0);
    check("rst_flags", 64'({req_full, err_ovf, err_coll}), 64'd0);
    check("rst_rdata_pass", 64'({rdata_v, rdata}), 64'({1'b1, 32'hCAFEF00D}));
    cpu_rdata_v = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(2);

    // Single write: pulse two cycles after the edge cycle.
    base = pulse_cnt;
    host_req(1'b1, 4'hF, 4'h3, 32'hDEADBEEF, 1'b1);
    wait_pulse(10, at);
    check("wr_latency", 64'(at - drive_cyc), 64'd2);
    tick(8);
    check("wr_count", 64'(pulse_cnt - base), 64'd1);

    // Single read with a 5-cycle busy bus and combinational read data return.
    base = pulse_cnt;
    host_req(1'b0, 4'hF, 4'hA, 32'h0, 1'b1);
    wait_pulse(10, at);
    check("rd_latency", 64'(at - drive_cyc), 64'd2);
    trans_over = 1'b0;
    tick(5);
    cpu_rdata   = 32'h12345678;
    cpu_rdata_v = 1'b1;
    trans_over  = 1'b1;
    #1;
    check("rd_data", 64'({rdata_v, rdata}), 64'({1'b1, 32'h12345678}));
    tick(1);
    cpu_rdata_v = 1'b0;
    tick(10);
    check("rd_count", 64'(pulse_cnt - base), 64'd1);

    // Fill while bus busy, overflow, then drain in order.
    base = pulse_cnt;
    trans_over = 1'b0;
    for (int i = 0; i < 4; i++) host_req(1'b1, 4'(i + 1), 4'(i + 4), 32'hA0 + 32'(i), 1'b1);
    check("fill_level", 64'(req_level), 64'd4);
    check("fill_full", 64'(req_full), 64'd1);
    check("fill_ovf_clear", 64'(err_ovf), 64'd0);
    host_req(1'b1, 4'h5, 4'h9, 32'hBAD, 1'b0);
    check("ovf_set", 64'(err_ovf), 64'd1);
    check("ovf_level", 64'(req_level), 64'd4);
    trans_over = 1'b1;
    wait_count("drain4", base + 4, 60);
    tick(4);
    check("drain_level", 64'({req_full, req_level}), 64'd0);
    check("ovf_sticky", 64'(err_ovf), 64'd1);
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    check("ovf_cleared", 64'(err_ovf), 64'd0);

    // Full FIFO with a pop in the same cycle accepts the new request.
    base = pulse_cnt;
    trans_over = 1'b0;
    for (int i = 0; i < 4; i++) host_req(i[0], 4'hC, 4'(i), 32'h5000 + 32'(i), 1'b1);
    check("full_again", 64'(req_full), 64'd1);
    trans_over = 1'b1;
    host_req(1'b1, 4'h3, 4'hE, 32'h0F0F0F0F, 1'b1);
    check("pop_push_no_ovf", 64'(err_ovf), 64'd0);
    wait_count("drain5", base + 5, 80);
    tick(4);

    // Simultaneous wr/rd edges: write only, collision flag wins over clear.
    base = pulse_cnt;
    byte_en = 4'h6;
    addr    = 4'h7;
    wdata   = 32'h01020304;
    wr      = 1'b1;
    rd      = 1'b1;
    clr_err = 1'b1;
    sb.push_back({1'b1, 4'h6, 4'h7, 32'h01020304});
    tick(1);
    wr      = 1'b0;
    rd      = 1'b0;
    clr_err = 1'b0;
    check("coll_set", 64'(err_coll), 64'd1);
    tick(10);
    check("coll_count", 64'(pulse_cnt - base), 64'd1);
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    check("coll_cleared", 64'(err_coll), 64'd0);

    // Level held high yields a single request.
    base = pulse_cnt;
    byte_en = 4'h1;
    addr    = 4'h2;
    wdata   = 32'h77;
    wr      = 1'b1;
    sb.push_back({1'b1, 4'h1, 4'h2, 32'h77});
    tick(20);
    wr = 1'b0;
    tick(10);
    check("held_count", 64'(pulse_cnt - base), 64'd1);

    // Reset while waiting with three entries queued.
    host_req(1'b1, 4'h8, 4'h1, 32'h11111111, 1'b1);
    wait_pulse(10, at);
    trans_over = 1'b0;
    tick(1);
    for (int i = 0; i < 3; i++) host_req(1'b1, 4'h2, 4'(i), 32'hEE00 + 32'(i), 1'b0);
    check("pre_rst_level", 64'(req_level), 64'd3);
    rst_n = 1'b0;
    #1;
    check("mid_rst_pulse", 64'({cpu_wr, cpu_rd}), 64'd0);
    check("mid_rst_fields", 64'({cpu_byte, cpu_addr, cpu_wdata}), 64'd0);
    check("mid_rst_level", 64'({req_full, req_level}), 64'd0);
    tick(2);
    rst_n      = 1'b1;
    trans_over = 1'b1;
    base       = pulse_cnt;
    tick(15);
    check("post_rst_quiet", 64'(pulse_cnt - base), 64'd0);
    host_req(1'b0, 4'h4, 4'hB, 32'h0, 1'b1);
    wait_pulse(10, at);
    check("post_rst_latency", 64'(at - drive_cyc), 64'd2);
    tick(6);
    check("post_rst_count", 64'(pulse_cnt - base), 64'd1);

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/cpu_req_queue.md
# cpu_req_queue

Parametrised CPU-side request front-end between the host stimulus port (wr/rd/byte/addr/wdata) and the bus transfer engine. It edge-detects host write/read strobes and buffers each request in a DEPTH-entry FIFO. Buffered requests are issued to the bus one at a time as single-cycle cpu_wr/cpu_rd pulses, paced by trans_over, so host requests are queued while the bus is busy instead of being dropped. Read data returns combinationally. Overflow and collision events are flagged sticky.

## Interface
- AW, 4: address width
- DW, 32: data width; multiple of 8
- BW, DW/8: byte-enable width
- DEPTH, 4: request FIFO depth; power of 2, ≥2
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- wr  in  1  host write strobe (level; rising edge = request)
- rd  in  1  host read strobe (level; rising edge = request)
- byte  in  BW  host byte enables
- addr  in  AW  host address
- wdata  in  DW  host write data
- clr_err  in  1  clears sticky error flags
- rdata_v  out  1  read data valid (= cpu_rdata_v)
- rdata  out  DW  read data (= cpu_rdata)
- cpu_wr  out  1  bus write command pulse
- cpu_rd  out  1  bus read command pulse
- cpu_byte  out  BW  bus byte enables
- cpu_addr  out  AW  bus address
- cpu_wdata  out  DW  bus write data
- cpu_rdata_v  in  1  bus read data valid
- cpu_rdata  in  DW  bus read data
- trans_over  in  1  1 = bus idle/ready; drops the cycle after a command, rises on completion
- req_level  out  $clog2(DEPTH)+1  FIFO occupancy
- req_full  out  1  FIFO full
- err_ovf  out  1  sticky: request arrived while full (request dropped)
- err_coll  out  1  sticky: wr and rd rising edges in the same cycle

## Operation
- wr_ff/rd_ff register wr/rd. Edge: we = wr&~wr_ff, re = rd&~rd_ff.
- Enqueue entry {is_wr, byte, addr, wdata} sampled in the edge cycle. is_wr=1 for we.
- we&re together: enqueue write only, drop read, set err_coll.
- Edge while full and no pop in the same cycle: drop, set err_ovf. Full with a pop in the same cycle: enqueue accepted.
- FSM IDLE/ISSUE/WAIT:
  - IDLE: if FIFO non-empty & trans_over=1, pop head into output registers → ISSUE.
  - ISSUE: cpu_wr = is_wr, cpu_rd = ~is_wr, high this cycle only → WAIT.
  - WAIT: ignore the first WAIT cycle. Thereafter, trans_over=1 → IDLE.
- cpu_byte/addr/wdata hold the last issued entry until the next pop.
- rdata_v/rdata pass through combinationally. There is no reordering; at most one transfer is outstanding.
- clr_err clears both flags. A set event in the same cycle wins over clr_err.
- Reset values: all outputs 0 (rdata/rdata_v follow their inputs), FIFO empty, FSM IDLE, wr_ff=rd_ff=0.

## Timing
- Empty FIFO, idle bus: edge in cycle N → enqueue at N → pop at N+1 → pulse at N+2. Minimum issue latency is 2 cycles.
- Back-to-back transfers: pulse, then at least 2 WAIT cycles, then IDLE. Issue-to-issue spacing ≥4 cycles.
- A wr or rd level held high produces exactly one request.
- Reset mid-transfer aborts immediately. Queued entries are lost, and no pulse is issued after reset release until a new edge arrives.
- FIFO pointers wrap modulo DEPTH. req_level is exact, 0..DEPTH.

## Structure
- Package cpu_req_pkg holds the FSM state enum, the entry struct/width function (1+BW+AW+DW), and the error bit indices.
- Sub-module cpu_req_fifo: synchronous single-clock FIFO with parameters WIDTH/DEPTH, push/pop/full/empty/level, and defined simultaneous push+pop when full or empty.
- Top contains the edge detect, enqueue arbitration, FSM, output registers and error flags.

## Test plan
- Single write, addr=4'h3, byte=4'hF, wdata=32'hDEADBEEF, trans_over=1 → cpu_wr pulse 2 cycles after the edge, fields match, one cycle wide.
- Single read at addr 4'hA. Bus drops trans_over for 5 cycles, then returns cpu_rdata=32'h12345678 with cpu_rdata_v → rdata_v/rdata match the same cycle. No second pulse.
- 4 writes while trans_over=0 → req_level=4, req_full=1. A 5th write sets err_ovf and is dropped. Raise trans_over → 4 pulses in FIFO order, then clr_err clears err_ovf.
- wr and rd rise in the same cycle → one cpu_wr pulse only, err_coll=1.
- wr held high 20 cycles → exactly one request.
- Assert rst_n=0 with 3 entries queued in WAIT → all outputs 0, req_level=0. After release, no pulses occur until a new edge.
